// File: rtl/bram_instr_arbiter_pkg.sv
// Shared types and instruction-word field positions for the BRAM instruction arbiter.
package bram_instr_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } arb_state_e;

  localparam int TDATA_W  = 64;
  localparam int OP_BIT   = 26;
  localparam int ADDR_MSB = 25;
  localparam int ADDR_LSB = 13;
  localparam int LEN_MSB  = 12;
  localparam int LEN_LSB  = 0;

endpackage

// File: rtl/bram_instr_arbiter.sv
// Two-requester round-robin arbiter feeding one instruction at a time to a BRAM stream slave.
// Optional WAIT-state watchdog is enabled by defining ARB_TIMEOUT_EN.
module bram_instr_arbiter
  import bram_instr_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [TDATA_W-1:0] s_req0_tdata,
  input  logic               s_req0_tvalid,
  output logic               s_req0_tready,
  input  logic [TDATA_W-1:0] s_req1_tdata,
  input  logic               s_req1_tvalid,
  output logic               s_req1_tready,
  output logic [TDATA_W-1:0] m_instruct_tdata,
  output logic               m_instruct_tvalid,
  input  logic               m_instruct_tready,
  input  logic               wr_done,
  input  logic               rd_done,
  output logic [1:0]         grant,
  output logic               busy,
  output logic               zero_len_drop,
  output logic               timeout
);

  arb_state_e         r_state;
  arb_state_e         w_next_state;
  logic               r_ptr;
  logic [1:0]         r_grant;
  logic               r_op;
  logic [TDATA_W-1:0] r_tdata;
  logic               r_zero_drop;

  logic               w_any_valid;
  logic               w_pick1;
  logic               w_accept;
  logic [TDATA_W-1:0] w_sel_data;
  logic               w_len_zero;
  logic               w_done;
  logic               w_tmo_hit;

  // r_ptr names the preferred requester; the other wins only when the preferred one is idle.
  assign w_any_valid = s_req0_tvalid | s_req1_tvalid;
  assign w_pick1     = r_ptr ? s_req1_tvalid : ~s_req0_tvalid;
  assign w_accept    = rst_n & (r_state == IDLE) & w_any_valid;
  assign w_sel_data  = w_pick1 ? s_req1_tdata : s_req0_tdata;
  assign w_len_zero  = (w_sel_data[LEN_MSB:LEN_LSB] == '0);
  assign w_done      = r_op ? rd_done : wr_done;

  assign s_req0_tready     = w_accept & ~w_pick1;
  assign s_req1_tready     = w_accept & w_pick1;
  assign m_instruct_tvalid = (r_state == ISSUE);
  assign m_instruct_tdata  = r_tdata;
  assign grant             = r_grant;
  assign busy              = (r_state != IDLE);
  assign zero_len_drop     = r_zero_drop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (w_accept && !w_len_zero) w_next_state = ISSUE;
      ISSUE:   if (m_instruct_tready)       w_next_state = WAIT;
      WAIT:    if (w_done || w_tmo_hit)     w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // Zero-length instructions are consumed without taking ownership, so grant stays 00.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr       <= 1'b0;
      r_grant     <= 2'b00;
      r_op        <= 1'b0;
      r_tdata     <= '0;
      r_zero_drop <= 1'b0;
    end else begin
      r_zero_drop <= w_accept & w_len_zero;
      if (w_accept) begin
        r_ptr <= ~w_pick1;
        if (!w_len_zero) begin
          r_grant <= w_pick1 ? 2'b10 : 2'b01;
          r_tdata <= w_sel_data;
          r_op    <= w_sel_data[OP_BIT];
        end
      end
      if (r_state == WAIT && (w_done || w_tmo_hit)) r_grant <= 2'b00;
    end
  end

`ifdef ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] r_wait_cnt;
  logic             r_timeout;

  // Count is zero on the first WAIT cycle, so the limit is reached after TIMEOUT_CYCLES cycles.
  assign w_tmo_hit = (r_state == WAIT) && (r_wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
  assign timeout   = r_timeout;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wait_cnt <= '0;
      r_timeout  <= 1'b0;
    end else begin
      if (r_state == WAIT) r_wait_cnt <= r_wait_cnt + CNT_W'(1);
      else                 r_wait_cnt <= '0;
      if (w_tmo_hit) r_timeout <= 1'b1;
    end
  end
`else
  logic w_unused_tmo_param;

  assign w_unused_tmo_param = (TIMEOUT_CYCLES == 0);
  assign w_tmo_hit          = 1'b0;
  assign timeout            = 1'b0;
`endif

endmodule

// File: tb/tb_bram_instr_arbiter.sv
// Directed scoreboard bench for bram_instr_arbiter; forwarded instructions are checked against a queue.
module tb_bram_instr_arbiter;
  import bram_instr_arbiter_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [63:0] s_req0_tdata, s_req1_tdata;
  logic        s_req0_tvalid, s_req1_tvalid;
  logic        s_req0_tready, s_req1_tready;
  logic [63:0] m_instruct_tdata;
  logic        m_instruct_tvalid, m_instruct_tready;
  logic        wr_done, rd_done;
  logic [1:0]  grant;
  logic        busy, zero_len_drop, timeout;

  int vectors = 0;
  int miscompares = 0;
  logic [63:0] exp_q[$];
  logic [63:0] exp_v;

  bram_instr_arbiter #(.TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_req0_tdata(s_req0_tdata), .s_req0_tvalid(s_req0_tvalid), .s_req0_tready(s_req0_tready),
    .s_req1_tdata(s_req1_tdata), .s_req1_tvalid(s_req1_tvalid), .s_req1_tready(s_req1_tready),
    .m_instruct_tdata(m_instruct_tdata), .m_instruct_tvalid(m_instruct_tvalid),
    .m_instruct_tready(m_instruct_tready),
    .wr_done(wr_done), .rd_done(rd_done),
    .grant(grant), .busy(busy), .zero_len_drop(zero_len_drop), .timeout(timeout)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] mk(input logic op, input logic [12:0] addr,
                                     input logic [12:0] len, input logic [36:0] hi);
    return {hi, op, addr, len};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Handshakes are observed at the falling edge, ahead of the rising edge that completes them.
  task automatic tick();
    @(negedge clk);
    if (m_instruct_tvalid === 1'b1 && m_instruct_tready === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("sb_unexpected", m_instruct_tdata, 64'h0);
        if (m_instruct_tdata == 64'h0) begin
          miscompares++;
          $error("FAIL sb_unexpected: observed forward with empty scoreboard, expected none");
        end
      end else begin
        exp_v = exp_q.pop_front();
        chk("sb_tdata", m_instruct_tdata, exp_v);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_grant"},  grant, 2'b00);
    chk({tag, "_busy"},   busy, 1'b0);
    chk({tag, "_tvalid"}, m_instruct_tvalid, 1'b0);
    chk({tag, "_tdata"},  m_instruct_tdata, 64'h0);
    chk({tag, "_rdy0"},   s_req0_tready, 1'b0);
    chk({tag, "_rdy1"},   s_req1_tready, 1'b0);
    chk({tag, "_zdrop"},  zero_len_drop, 1'b0);
    chk({tag, "_tmo"},    timeout, 1'b0);
  endtask

  logic [63:0] R0, R1, Z1, W0, T1;

  initial begin
    R0 = mk(1'b1, 13'h0123, 13'd8, 37'h12_3456_789A);
    R1 = mk(1'b0, 13'h0456, 13'd5, 37'h05_5555_AAAA);
    Z1 = mk(1'b0, 13'h0001, 13'd0, 37'h00_0000_ABCD);
    W0 = mk(1'b0, 13'h0789, 13'd3, 37'h1F_0000_0001);
    T1 = mk(1'b0, 13'h1FFF, 13'd2, 37'h0A_BCDE_F012);

    rst_n = 1'b0;
    s_req0_tdata = R0; s_req1_tdata = R1;
    s_req0_tvalid = 1'b1; s_req1_tvalid = 1'b1;
    m_instruct_tready = 1'b0; wr_done = 1'b0; rd_done = 1'b0;
    #3;
    chk_reset_outputs("rst");
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    // Both valid out of reset: requester 0 preferred.
    chk("a_rdy0", s_req0_tready, 1'b1);
    chk("a_rdy1", s_req1_tready, 1'b0);
    exp_q.push_back(R0);
    tick();
    s_req0_tvalid = 1'b0;
    #1;
    chk("a_grant", grant, 2'b01);
    // Stall the slave for five cycles: output must hold and no requester is ready.
    for (int i = 0; i < 5; i++) begin
      chk("stall_tvalid", m_instruct_tvalid, 1'b1);
      chk("stall_tdata",  m_instruct_tdata, R0);
      chk("stall_rdy1",   s_req1_tready, 1'b0);
      chk("stall_rdy0",   s_req0_tready, 1'b0);
      tick();
    end
    m_instruct_tready = 1'b1;
    tick();
    m_instruct_tready = 1'b0;
    #1;
    chk("wait_tvalid", m_instruct_tvalid, 1'b0);
    chk("wait_busy", busy, 1'b1);
    wr_done = 1'b1;
    tick();
    wr_done = 1'b0;
    #1;
    chk("rd_ign_wr_busy", busy, 1'b1);
    chk("rd_ign_wr_grant", grant, 2'b01);
    rd_done = 1'b1;
    #1;
    chk("done_cycle_rdy1", s_req1_tready, 1'b0);
    tick();
    rd_done = 1'b0;
    #1;
    chk("a_done_grant", grant, 2'b00);
    chk("a_done_busy", busy, 1'b0);
    chk("b_rdy1", s_req1_tready, 1'b1);
    exp_q.push_back(R1);
    tick();
    s_req1_tvalid = 1'b0;
    #1;
    chk("b_grant", grant, 2'b10);
    m_instruct_tready = 1'b1;
    tick();
    m_instruct_tready = 1'b0;
    // Write outstanding: a read completion must not release it.
    rd_done = 1'b1;
    tick();
    rd_done = 1'b0;
    #1;
    chk("wr_ign_rd_busy", busy, 1'b1);
    chk("wr_ign_rd_grant", grant, 2'b10);
    wr_done = 1'b1;
    tick();
    wr_done = 1'b0;
    #1;
    chk("b_done_grant", grant, 2'b00);
    chk("b_done_busy", busy, 1'b0);

    // Zero-length instruction from requester 1.
    s_req1_tdata = Z1; s_req1_tvalid = 1'b1;
    #1;
    chk("z_rdy1", s_req1_tready, 1'b1);
    tick();
    s_req1_tvalid = 1'b0;
    #1;
    chk("z_pulse", zero_len_drop, 1'b1);
    chk("z_busy", busy, 1'b0);
    chk("z_grant", grant, 2'b00);
    chk("z_tvalid", m_instruct_tvalid, 1'b0);
    s_req0_tdata = W0; s_req0_tvalid = 1'b1;
    s_req1_tdata = R1; s_req1_tvalid = 1'b1;
    #1;
    chk("z_ptr_rdy0", s_req0_tready, 1'b1);
    chk("z_ptr_rdy1", s_req1_tready, 1'b0);
    exp_q.push_back(W0);
    tick();
    s_req0_tvalid = 1'b0; s_req1_tvalid = 1'b0;
    #1;
    chk("z_pulse_end", zero_len_drop, 1'b0);
    chk("c_grant", grant, 2'b01);
    m_instruct_tready = 1'b1;
    tick();
    m_instruct_tready = 1'b0;
    wr_done = 1'b1;
    tick();
    wr_done = 1'b0;
    #1;
    chk("c_done_busy", busy, 1'b0);

    // Outstanding write with no completion for 16 WAIT cycles.
    s_req1_tdata = T1; s_req1_tvalid = 1'b1;
    exp_q.push_back(T1);
    tick();
    s_req1_tvalid = 1'b0;
    m_instruct_tready = 1'b1;
    tick();
    m_instruct_tready = 1'b0;
    for (int i = 0; i < 15; i++) tick();
    chk("t15_busy", busy, 1'b1);
    chk("t15_tmo", timeout, 1'b0);
    tick();
`ifdef ARB_TIMEOUT_EN
    chk("t16_tmo", timeout, 1'b1);
    chk("t16_busy", busy, 1'b0);
    chk("t16_grant", grant, 2'b00);
    tick();
    tick();
    chk("t_hold_tmo", timeout, 1'b1);
`else
    chk("t16_tmo", timeout, 1'b0);
    chk("t16_busy", busy, 1'b1);
    chk("t16_grant", grant, 2'b10);
    wr_done = 1'b1;
    tick();
    wr_done = 1'b0;
    #1;
    chk("t_done_busy", busy, 1'b0);
`endif

    // Reset in the middle of WAIT, then the same request re-arbitrated fresh.
    s_req0_tdata = W0; s_req0_tvalid = 1'b1;
    exp_q.push_back(W0);
    tick();
    m_instruct_tready = 1'b1;
    tick();
    m_instruct_tready = 1'b0;
    #1;
    chk("r_pre_busy", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("midwait");
    tick();
    tick();
    chk_reset_outputs("held");
    rst_n = 1'b1;
    #1;
    chk("r_rdy0", s_req0_tready, 1'b1);
    exp_q.push_back(W0);
    tick();
    s_req0_tvalid = 1'b0;
    #1;
    chk("r_grant", grant, 2'b01);
    chk("r_tvalid", m_instruct_tvalid, 1'b1);
    m_instruct_tready = 1'b1;
    tick();
    m_instruct_tready = 1'b0;
    wr_done = 1'b1;
    tick();
    wr_done = 1'b0;
    #1;
    chk("r_done_busy", busy, 1'b0);
    chk("sb_empty", 64'(exp_q.size()), 64'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
